// File: rtl/mips_reg_checker.sv
// mips_reg_checker
// ----------------
// Self-checking harness that sits beside the Mips core. A check is started
// with `start`. The RUN phase then lasts until the core raises `halt` or the
// cycle budget runs out. The SWEEP phase walks the architectural register file
// through the core's readout port. Each register is compared against an
// external expected-value table. DONE reports pass/fail, the mismatch count
// and the first failing register.
//
// Ports:
//   clock          - single clock, rising edge
//   reset          - asynchronous, active-low
//   start          - begin a check (acted on in IDLE or DONE only)
//   halt           - core finished its program; ends RUN early
//   reg_out_id     - register index driven to the core readout port
//   reg_out_data   - register value returned by the core
//   exp_addr       - expected-table index (always equal to reg_out_id)
//   exp_data       - expected value from the table (combinational)
//   exp_valid      - 0 marks a don't-care register
//   busy           - RUN or SWEEP in progress
//   done           - check complete (level)
//   pass           - done with zero mismatches
//   timed_out      - RUN ended by the cycle budget rather than by halt
//   mismatch_count - number of mismatching registers
//   first_fail_*   - index / core value / expected value of the first mismatch
//   cycle_count    - RUN-phase cycles elapsed (frozen after RUN)

module mips_reg_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_REGS       = 32,
  parameter int RUN_CYCLES     = 500,
  parameter int READ_LATENCY   = 0,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      halt,
  output logic [REG_ADDR_WIDTH-1:0] reg_out_id,
  input  logic [DATA_WIDTH-1:0]     reg_out_data,
  output logic [REG_ADDR_WIDTH-1:0] exp_addr,
  input  logic [DATA_WIDTH-1:0]     exp_data,
  input  logic                      exp_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timed_out,
  output logic [REG_ADDR_WIDTH:0]   mismatch_count,
  output logic [REG_ADDR_WIDTH-1:0] first_fail_id,
  output logic [DATA_WIDTH-1:0]     first_fail_got,
  output logic [DATA_WIDTH-1:0]     first_fail_exp,
  output logic [CNT_WIDTH-1:0]      cycle_count
);

  localparam logic [REG_ADDR_WIDTH-1:0] LAST_ID  = REG_ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [REG_ADDR_WIDTH-1:0] ID_ONE   = REG_ADDR_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH:0]   MM_ONE   = (REG_ADDR_WIDTH + 1)'(1);
  localparam logic [CNT_WIDTH-1:0]      RUN_LAST = CNT_WIDTH'(RUN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]      CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [1:0]                LAT      = 2'(READ_LATENCY);

  typedef enum logic [1:0] {IDLE, RUN, SWEEP, DONE} state_t;

  state_t     state;
  logic [1:0] wait_cnt;
  logic       is_mismatch;

  // The table is indexed by the same register number the core is reading.
  assign exp_addr    = reg_out_id;
  assign is_mismatch = exp_valid && (reg_out_data != exp_data);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      reg_out_id     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timed_out      <= 1'b0;
      mismatch_count <= '0;
      first_fail_id  <= '0;
      first_fail_got <= '0;
      first_fail_exp <= '0;
      cycle_count    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // Start (or re-arm) clears every result from the previous check.
          if (start) begin
            state          <= RUN;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            timed_out      <= 1'b0;
            mismatch_count <= '0;
            first_fail_id  <= '0;
            first_fail_got <= '0;
            first_fail_exp <= '0;
            cycle_count    <= '0;
          end
        end

        RUN: begin
          // cycle_count only advances while RUN continues, so it freezes at
          // the index of the last RUN cycle. halt takes priority over budget.
          if (halt || (cycle_count == RUN_LAST)) begin
            state      <= SWEEP;
            timed_out  <= !halt;
            reg_out_id <= '0;
            wait_cnt   <= '0;
          end else begin
            cycle_count <= cycle_count + CNT_ONE;
          end
        end

        SWEEP: begin
          if (wait_cnt != LAT) begin
            wait_cnt <= wait_cnt + 2'd1;
          end else begin
            if (is_mismatch) begin
              mismatch_count <= mismatch_count + MM_ONE;
              // A zero count means this is the first mismatch of the check.
              if (mismatch_count == '0) begin
                first_fail_id  <= reg_out_id;
                first_fail_got <= reg_out_data;
                first_fail_exp <= exp_data;
              end
            end
            if (reg_out_id == LAST_ID) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (mismatch_count == '0) && !is_mismatch;
            end else begin
              reg_out_id <= reg_out_id + ID_ONE;
              wait_cnt   <= '0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
